// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl_if
// Description : Data-memory bus between the MEM-stage load/store controller
//               (master) and the data memory (slave). req/gnt request phase,
//               rvalid/rdata response phase for loads.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : MEM-stage load/store controller. Builds byte enables and
//               lane-replicated store data, runs the req/gnt/rvalid bus
//               handshake, stalls the pipeline until the access completes and
//               presents the registered raw load word plus its byte offset.
//               Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word
//               accesses are not issued and flagged on misalignM).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  MemReadM,
    input  wire logic                  MemWriteM,
    input  wire logic [2:0]            funct3M,
    input  wire logic [ADDR_WIDTH-1:0] ALUResultM,
    input  wire logic [31:0]           WriteDataM,
    input  wire logic                  FlushM,
    lsu_mem_ctrl_if.master             bus,
    output logic                       StallM,
    output logic [31:0]                RD_data,
    output logic [1:0]                 byteAddrM,
    output logic                       misalignM
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            pend_ba_q, pend_ba_d;     // offset of the access in flight
    logic                  flushed_q, flushed_d;     // load killed while awaiting rvalid
    logic [31:0]           rd_data_q, rd_data_d;
    logic [1:0]            byte_addr_q, byte_addr_d;
    logic                  misal_q, misal_d;

    logic                  w_op;
    logic                  w_size_ok;
    logic                  w_misal;
    logic                  w_req;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;

    assign w_op = (MemReadM | MemWriteM) & ~FlushM;

    // Decode access size into byte enables and lane-replicated store data
    always_comb begin
        w_be      = 4'b0000;
        w_wdata   = 32'h0;
        w_size_ok = 1'b1;
        case (funct3M)
            3'b000, 3'b100: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            3'b001, 3'b101: begin
                w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
            default: w_size_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Half needs an even address, word needs a word-aligned address
    assign w_misal = ((funct3M == 3'b001 || funct3M == 3'b101) && ALUResultM[0])
                   || ((funct3M == 3'b010) && (ALUResultM[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    // Next-state, captured fields and handshake outputs
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        pend_ba_d   = pend_ba_q;
        flushed_d   = flushed_q;
        rd_data_d   = rd_data_q;
        byte_addr_d = byte_addr_q;
        misal_d     = misal_q;
        StallM      = 1'b0;
        w_req       = 1'b0;
        case (state_q)
            S_IDLE: begin
                StallM    = w_op;
                flushed_d = 1'b0;
                misal_d   = 1'b0;
                if (w_op) begin
                    if (!w_size_ok || w_misal) begin
                        // Nothing goes on the bus; release the stall after one DONE cycle
                        misal_d = w_misal;
                        state_d = S_DONE;
                    end else begin
                        addr_d    = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                        we_d      = MemWriteM;
                        be_d      = w_be;
                        wdata_d   = w_wdata;
                        pend_ba_d = ALUResultM[1:0];
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_req  = 1'b1;
                StallM = 1'b1;
                if (bus.mem_gnt) begin
                    // Once granted the access is committed; a late flush only drops the data
                    flushed_d = FlushM;
                    state_d   = we_q ? S_DONE : S_WAIT;
                end else if (FlushM) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                StallM = 1'b1;
                if (FlushM) begin
                    flushed_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    if (flushed_q || FlushM) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_data_d   = bus.mem_rdata;
                        byte_addr_d = pend_ba_q;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-field registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            pend_ba_q   <= 2'b00;
            flushed_q   <= 1'b0;
            rd_data_q   <= 32'h0;
            byte_addr_q <= 2'b00;
            misal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            pend_ba_q   <= pend_ba_d;
            flushed_q   <= flushed_d;
            rd_data_q   <= rd_data_d;
            byte_addr_q <= byte_addr_d;
            misal_q     <= misal_d;
        end
    end

    assign bus.mem_req   = w_req;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign RD_data       = rd_data_q;
    assign byteAddrM     = byte_addr_q;
    assign misalignM     = (state_q == S_DONE) & misal_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Self-checking bench for lsu_mem_ctrl: vector table of single
//               accesses against a responding memory model, bus-request
//               scoreboard, and hand sequences for flush and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int ADDR_WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM, FlushM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM;
    logic [31:0] RD_data;
    logic [1:0]  byteAddrM;
    logic        misalignM;

    lsu_mem_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .FlushM     (FlushM),
        .bus        (bus),
        .StallM     (StallM),
        .RD_data    (RD_data),
        .byteAddrM  (byteAddrM),
        .misalignM  (misalignM)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          fl;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          gd;      // REQ cycles before gnt
        int          rvd;     // extra cycles after gnt before rvalid
        logic [31:0] rdata;
        bit          mis;     // misaligned for its size
        logic [3:0]  be;      // expected enables when issued
        logic [31:0] wdata;   // expected bus data when issued
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    bus_t        sbq[$];
    vec_t        vt[12];
    int          n_chk = 0;
    int          n_fail = 0;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rv_data;
    logic [31:0] exp_rd;
    logic [1:0]  exp_ba;

    function automatic vec_t mk(bit rd, bit wr, bit fl, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, int gd, int rvd, logic [31:0] rdata,
                                bit mis, logic [3:0] be, logic [31:0] wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.fl = fl; v.f3 = f3; v.a = a; v.wd = wd;
        v.gd = gd; v.rvd = rvd; v.rdata = rdata; v.mis = mis; v.be = be; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the sampling edge and score any bus request against the queue
    task automatic tick();
        bus_t e;
        @(negedge clk);
        if (bus.mem_req) begin
            chk("req_expected", 128'(sbq.size() > 0), 128'(1));
            if (sbq.size() > 0) begin
                e = sbq[0];
                chk("bus_fields",
                    128'({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}),
                    128'({e.we, e.addr, e.be, e.wdata}));
                if (bus.mem_gnt) void'(sbq.pop_front());
            end
        end
    endtask

    // Memory model: grant after gnt_dly REQ cycles, answer loads rv_dly cycles later
    initial begin : responder
        int          gcnt;
        int          rcnt;
        bit          pend;
        logic [31:0] pdata;
        gcnt = 0; rcnt = 0; pend = 1'b0; pdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (rcnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = pdata;
                    pend = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (bus.mem_req) begin
                if (gcnt >= gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    gcnt = 0;
                    if (!bus.mem_we) begin
                        pend = 1'b1; rcnt = rv_dly; pdata = rv_data;
                    end
                end else begin
                    gcnt++;
                end
            end else begin
                gcnt = 0;
            end
        end
    end

    task automatic clear_inputs();
        MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b0;
        funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0;
    endtask

    task automatic drive(input bit rd, input bit wr, input bit fl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemReadM = rd; MemWriteM = wr; FlushM = fl;
        funct3M = f3; ALUResultM = a; WriteDataM = wd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit   op, valid, trap, issue, done;
        int   exp_stall, stalls, guard;
        logic mis_seen;
        bus_t e;
        op    = (v.rd | v.wr) & ~v.fl;
        valid = (v.f3 == 3'b000) || (v.f3 == 3'b100) || (v.f3 == 3'b001)
             || (v.f3 == 3'b101) || (v.f3 == 3'b010);
`ifdef MISALIGN_TRAP_EN
        trap = v.mis;
`else
        trap = 1'b0;
`endif
        issue = op & valid & ~trap;
        if (!op)        exp_stall = 0;
        else if (!issue) exp_stall = 1;
        else if (v.wr)  exp_stall = 2 + v.gd;
        else            exp_stall = 3 + v.gd + v.rvd;
        gnt_dly = v.gd; rv_dly = v.rvd; rv_data = v.rdata;
        if (issue) begin
            e.we = v.wr; e.addr = {v.a[31:2], 2'b00}; e.be = v.be; e.wdata = v.wdata;
            sbq.push_back(e);
        end
        if (issue && v.rd) begin
            exp_rd = v.rdata; exp_ba = v.a[1:0];
        end
        @(posedge clk); #1;
        drive(v.rd, v.wr, v.fl, v.f3, v.a, v.wd);
        stalls = 0; done = 1'b0; guard = 0; mis_seen = 1'b0;
        while (!done && guard < 40) begin
            tick();
            guard++;
            if (StallM) stalls++;
            else begin
                done = 1'b1;
                mis_seen = misalignM;
            end
        end
        chk($sformatf("v%0d_completes", idx), 128'(done), 128'(1));
        chk($sformatf("v%0d_stall_cycles", idx), 128'(stalls), 128'(exp_stall));
        chk($sformatf("v%0d_RD_data", idx), 128'(RD_data), 128'(exp_rd));
        chk($sformatf("v%0d_byteAddrM", idx), 128'(byteAddrM), 128'(exp_ba));
        chk($sformatf("v%0d_misalignM", idx), 128'(mis_seen), 128'(op & valid & trap));
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin : main
        bus_t e;
        int   stalls;
        rst_n = 1'b0;
        clear_inputs();
        gnt_dly = 0; rv_dly = 0; rv_data = 32'h0;
        exp_rd = 32'h0; exp_ba = 2'b00;

        // Reset state, and StallM follows the IDLE equation even while in reset
        tick(); tick();
        chk("reset_bus", 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}), 128'(0));
        chk("reset_out", 128'({RD_data, byteAddrM, misalignM, StallM}), 128'(0));
        MemReadM = 1'b1; #1;
        chk("reset_stall_eq", 128'(StallM), 128'(1));
        MemReadM = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        //          rd    wr    fl    f3      addr         wdata        gd rvd rdata         mis   be       bus wdata
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
        vt[1]  = mk(1'b0, 1'b1, 1'b0, 3'b000, 32'h103, 32'hA5,       0, 0, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5);
        vt[2]  = mk(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'h1234BEEF, 4, 0, 32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF);
        vt[3]  = mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h101, 32'h0,        1, 2, 32'h11223344, 1'b0, 4'b0010, 32'h0);
        vt[4]  = mk(1'b1, 1'b0, 1'b0, 3'b101, 32'h106, 32'h0,        0, 1, 32'hCAFEF00D, 1'b0, 4'b1100, 32'h0);
        vt[5]  = mk(1'b0, 1'b1, 1'b0, 3'b010, 32'h3FC, 32'h89ABCDEF, 2, 0, 32'h0,        1'b0, 4'b1111, 32'h89ABCDEF);
        vt[6]  = mk(1'b1, 1'b0, 1'b0, 3'b011, 32'h200, 32'h0,        0, 0, 32'hBAD0BAD0, 1'b0, 4'b0000, 32'h0);
        vt[7]  = mk(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0,        0, 0, 32'hBAD1BAD1, 1'b0, 4'b1111, 32'h0);
        vt[8]  = mk(1'b0, 1'b0, 1'b0, 3'b010, 32'h300, 32'h0,        0, 0, 32'h0,        1'b0, 4'b1111, 32'h0);
        vt[9]  = mk(1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h55AA55AA, 1'b1, 4'b1111, 32'h0);
        vt[10] = mk(1'b0, 1'b1, 1'b0, 3'b001, 32'h105, 32'h0000ABCD, 0, 0, 32'h0,        1'b1, 4'b0011, 32'hABCDABCD);
        vt[11] = mk(1'b0, 1'b1, 1'b0, 3'b000, 32'h0,   32'hFFFFFF01, 1, 0, 32'h0,        1'b0, 4'b0001, 32'h01010101);

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], i);
        end

        // Flush while the request is still waiting for gnt: no transaction
        gnt_dly = 100;
        e.we = 1'b0; e.addr = 32'h100; e.be = 4'b1111; e.wdata = 32'h0;
        sbq.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        tick();
        chk("flreq_idle_stall", 128'(StallM), 128'(1));
        @(posedge clk); #1;
        FlushM = 1'b1;
        tick();
        chk("flreq_req_held", 128'({bus.mem_req, StallM}), 128'(2'b11));
        @(posedge clk); #1;
        clear_inputs();
        tick();
        chk("flreq_back_idle", 128'({bus.mem_req, StallM}), 128'(0));
        chk("flreq_not_granted", 128'(sbq.size()), 128'(1));
        if (sbq.size() > 0) void'(sbq.pop_front());
        chk("flreq_RD_data", 128'(RD_data), 128'(exp_rd));
        gnt_dly = 0;

        // Flush while waiting for rvalid: response absorbed, data discarded
        rv_dly = 2; rv_data = 32'h1234;
        e.we = 1'b0; e.addr = 32'h100; e.be = 4'b1111; e.wdata = 32'h0;
        sbq.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        stalls = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (StallM) stalls++;
            @(posedge clk); #1;
            if (c == 1) begin
                MemReadM = 1'b0;
                FlushM   = 1'b1;
            end
            if (c == 2) FlushM = 1'b0;
        end
        chk("flwait_stall_cycles", 128'(stalls), 128'(5));
        chk("flwait_RD_data", 128'(RD_data), 128'(exp_rd));
        chk("flwait_byteAddrM", 128'(byteAddrM), 128'(exp_ba));
        chk("flwait_idle", 128'({bus.mem_req, StallM, misalignM}), 128'(0));

        // Asynchronous reset during WAIT, response arrives after reset
        rv_dly = 3; rv_data = 32'h77777777;
        e.we = 1'b0; e.addr = 32'h200; e.be = 4'b1111; e.wdata = 32'h0;
        sbq.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h200, 32'h0);
        tick();
        @(posedge clk); #1;
        tick();
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rstwait_bus", 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}), 128'(0));
        chk("rstwait_out", 128'({RD_data, byteAddrM, misalignM, StallM}), 128'(0));
        exp_rd = 32'h0; exp_ba = 2'b00;
        tick();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rstwait_rvalid_ignored", 128'({RD_data, byteAddrM}), 128'({exp_rd, exp_ba}));
        chk("rstwait_idle", 128'({bus.mem_req, StallM, misalignM}), 128'(0));
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
